// File: rtl/operand_seq_pkg.sv
// ---------------------------------------------------------------------------
// operand_seq_pkg : state encodings shared by the operand sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package operand_seq_pkg;

  localparam int STATE_W = 2;

  // 2'b11 is never entered; the FSM treats it as a fault and recovers to LOAD_A
  typedef enum logic [STATE_W-1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    READY  = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner : synchroniser, optional debounce (DEBOUNCE_EN) and
//                      rising-edge single-cycle press pulse for one button
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module button_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_lvl;
  logic                   level;
  logic                   prev_q;
  logic                   prev_d;

  if (SYNC_STAGES < 2 || DB_CYCLES < 1) begin : g_bad_params
    $error("button_conditioner: SYNC_STAGES must be >= 2 and DB_CYCLES >= 1");
  end

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn};
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;

  // Counter tracks consecutive samples that disagree with the accepted level
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_lvl == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
      cnt_d   = '0;
      level_d = sync_lvl;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
`else
  assign level = sync_lvl;
`endif

  assign prev_d = level;
  assign pulse  = level & ~prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/operand_sequencer.sv
// ---------------------------------------------------------------------------
// operand_sequencer : two-press operand entry (a then b) for the subtracter;
//                     define DEBOUNCE_EN to enable the button debounce filters
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module operand_sequencer
  import operand_seq_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_enter,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             op_valid,
  output logic [1:0]       state_led
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sw_sync_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sw_sync_d;
  logic [WIDTH-1:0]                  sw_s;

  logic enter_pulse;
  logic clear_pulse;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             valid_q, valid_d;

  button_conditioner #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) u_enter (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_enter),
    .pulse (enter_pulse)
  );

  button_conditioner #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) u_clear (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_clear),
    .pulse (clear_pulse)
  );

  always_comb begin
    sw_sync_d = {sw_sync_q[SYNC_STAGES-2:0], sw};
  end

  assign sw_s = sw_sync_q[SYNC_STAGES-1];

  // Clear takes priority; op_valid drops in the same update that rewrites a
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    if (clear_pulse) begin
      state_d = LOAD_A;
      a_d     = '0;
      b_d     = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (enter_pulse) begin
            a_d     = sw_s;
            state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (enter_pulse) begin
            b_d     = sw_s;
            valid_d = 1'b1;
            state_d = READY;
          end
        end
        READY: begin
          if (enter_pulse) begin
            a_d     = sw_s;
            valid_d = 1'b0;
            state_d = LOAD_B;
          end
        end
        default: begin
          state_d = LOAD_A;
          a_d     = '0;
          b_d     = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync_q <= '0;
      state_q   <= LOAD_A;
      a_q       <= '0;
      b_q       <= '0;
      valid_q   <= 1'b0;
    end else begin
      sw_sync_q <= sw_sync_d;
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      valid_q   <= valid_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign op_valid  = valid_q;
  assign state_led = state_q;

endmodule

`default_nettype wire
